// File: rtl/usb_cdc_pkg.sv
// ----------------------------------------------------------------------------
// usb_cdc_pkg
//  Shared constants and helpers for the usb_cdc APB wrapper and its byte FIFOs.
//  Both RX and TX stream FIFOs and usb_cdc_apb take their default geometry
//  from here, so the wrapper's register map and the FIFOs cannot drift apart.
// ----------------------------------------------------------------------------
package usb_cdc_pkg;

   localparam int USB_CDC_FIFO_DW    = 8;
   localparam int USB_CDC_FIFO_DEPTH = 16;

   // Next value of a sticky status bit: a new event wins over a clear that
   // arrives on the same edge, so no event is ever silently lost.
   function automatic logic sticky_next(input logic cur,
                                        input logic set,
                                        input logic clr);
      return set | (cur & ~clr);
   endfunction

endpackage : usb_cdc_pkg

// File: rtl/usb_cdc_fifo_mem.sv
// ----------------------------------------------------------------------------
// usb_cdc_fifo_mem
//  DEPTH x DW register array for the usb_cdc stream FIFO. The write port is
//  synchronous and the read port is asynchronous, which gives the FIFO its
//  first-word-fall-through head. Storage is deliberately not reset.
//
//  Ports
//   PCLK   in  1   clock
//   we     in  1   write enable
//   waddr  in  AW  write address
//   wdata  in  DW  write data
//   raddr  in  AW  read address
//   rdata  out DW  read data (combinational from raddr)
// ----------------------------------------------------------------------------
module usb_cdc_fifo_mem
   import usb_cdc_pkg::*;
#(
   parameter int DW    = USB_CDC_FIFO_DW,
   parameter int DEPTH = USB_CDC_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          PCLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge PCLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : usb_cdc_fifo_mem

// File: rtl/usb_cdc_stream_fifo.sv
// ----------------------------------------------------------------------------
// usb_cdc_stream_fifo
//  Byte FIFO between the usb_cdc core and the APB register wrapper. One
//  instance buffers RX, another TX. First-word-fall-through, valid/ready on
//  both sides, full-depth level count, threshold flags and sticky
//  overflow/underflow bits feeding the wrapper's raw interrupt status.
//
//  Ports
//   PCLK        in  1     clock
//   PRESETn     in  1     asynchronous active-low reset
//   flush_i     in  1     synchronous flush, empties the FIFO
//   wr_valid_i  in  1     push request
//   wr_data_i   in  DW    push data
//   wr_ready_o  out 1     push accepted when wr_valid_i & wr_ready_o
//   rd_valid_o  out 1     head entry valid
//   rd_data_o   out DW    head entry
//   rd_ready_i  in  1     pop when rd_valid_o & rd_ready_i
//   th_i        in  AW+1  threshold for level compares
//   level_o     out AW+1  occupancy 0..DEPTH
//   empty_o     out 1     level_o == 0
//   full_o      out 1     level_o == DEPTH
//   above_th_o  out 1     level_o >  th_i
//   below_th_o  out 1     level_o <  th_i
//   ovf_o       out 1     sticky: push attempted while full
//   unf_o       out 1     sticky: pop attempted while empty
//   err_clr_i   in  1     clears ovf_o and unf_o
// ----------------------------------------------------------------------------
module usb_cdc_stream_fifo
   import usb_cdc_pkg::*;
#(
   parameter  int DW    = USB_CDC_FIFO_DW,
   parameter  int DEPTH = USB_CDC_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          flush_i,
   input  logic          wr_valid_i,
   input  logic [DW-1:0] wr_data_i,
   output logic          wr_ready_o,
   output logic          rd_valid_o,
   output logic [DW-1:0] rd_data_o,
   input  logic          rd_ready_i,
   input  logic [AW:0]   th_i,
   output logic [AW:0]   level_o,
   output logic          empty_o,
   output logic          full_o,
   output logic          above_th_o,
   output logic          below_th_o,
   output logic          ovf_o,
   output logic          unf_o,
   input  logic          err_clr_i
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

   // Pointers carry one extra wrap bit so that full and empty are
   // distinguishable and level can reach DEPTH without aliasing to 0.
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [AW:0] level;

   logic        push;
   logic        pop;
   logic        ovf_set;
   logic        unf_set;

   assign level   = wptr - rptr;
   assign level_o = level;
   assign empty_o = (level == '0);
   assign full_o  = (level == FULL_LVL);

   // Handshakes depend on registered state only: no ready->ready or
   // valid->valid combinational path through the FIFO.
   assign wr_ready_o = ~full_o;
   assign rd_valid_o = ~empty_o;

   assign push = wr_valid_i & wr_ready_o & ~flush_i;
   assign pop  = rd_ready_i & rd_valid_o & ~flush_i;

   // Refused requests are recorded; a flush swallows them without a flag.
   assign ovf_set = wr_valid_i & full_o  & ~flush_i;
   assign unf_set = rd_ready_i & empty_o & ~flush_i;

   assign above_th_o = (level > th_i);
   assign below_th_o = (level < th_i);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + PTR_ONE;
         end
         if (pop) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

   // Status flags are independent of flush so the wrapper's RIS survives it.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ovf_o <= 1'b0;
         unf_o <= 1'b0;
      end else begin
         ovf_o <= sticky_next(ovf_o, ovf_set, err_clr_i);
         unf_o <= sticky_next(unf_o, unf_set, err_clr_i);
      end
   end

   usb_cdc_fifo_mem #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .PCLK  (PCLK),
      .we    (push),
      .waddr (wptr[AW-1:0]),
      .wdata (wr_data_i),
      .raddr (rptr[AW-1:0]),
      .rdata (rd_data_o)
   );

endmodule : usb_cdc_stream_fifo
